// File: rtl/arf132b256e1r1w0cbbehcaa4acw_wr_ctrl_pkg.sv
// arf132b256e1r1w0cbbehcaa4acw_wr_ctrl_pkg: shared widths, FSM states and write-request record
// Contents: DWIDTH/DEPTH/AWIDTH/NREQ defaults, state_t (INIT, RUN), wreq_t {addr, data}
package arf132b256e1r1w0cbbehcaa4acw_wr_ctrl_pkg;
    localparam int DWIDTH = 132;
    localparam int DEPTH  = 256;
    localparam int AWIDTH = 8;
    localparam int NREQ   = 2;

    typedef enum logic {INIT, RUN} state_t;

    typedef struct packed {
        logic [AWIDTH-1:0] addr;
        logic [DWIDTH-1:0] data;
    } wreq_t;
endpackage

// File: rtl/arf132b256e1r1w0cbbehcaa4acw_rr_arb2.sv
// arf132b256e1r1w0cbbehcaa4acw_rr_arb2: 2-way round-robin arbiter owning the priority pointer
// Ports: clk, rst_n (async low), valid[1:0] requests, advance (a grant was taken),
//        grant[1:0] one-hot grant
module arf132b256e1r1w0cbbehcaa4acw_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);
    logic rr_ptr;

    // A lone requester always wins; the pointer only breaks ties.
    assign grant[0] = valid[0] & (~valid[1] | ~rr_ptr);
    assign grant[1] = valid[1] & (~valid[0] | rr_ptr);

    // After a transfer, priority passes to the requester that was not served.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            rr_ptr <= 1'b0;
        else if (advance)
            rr_ptr <= grant[0];
endmodule

// File: rtl/arf132b256e1r1w0cbbehcaa4acw_wr_ctrl.sv
// arf132b256e1r1w0cbbehcaa4acw_wr_ctrl: write-port controller for the 132b x 256 1R1W latch register file
// Ports: clk, rst_n (async low); wreq_valid/ready/addr/data two requesters (req0 in LSBs);
//        arr_wr_en/addr/data flopped array write port; rd_en/rd_addr read request,
//        rd_ready, arr_rd_data raw array data, rd_data bypassed read data; init_done
module arf132b256e1r1w0cbbehcaa4acw_wr_ctrl
    import arf132b256e1r1w0cbbehcaa4acw_wr_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        wreq_valid,
    output logic [NREQ-1:0]        wreq_ready,
    input  logic [NREQ*AWIDTH-1:0] wreq_addr,
    input  logic [NREQ*DWIDTH-1:0] wreq_data,
    output logic                   arr_wr_en,
    output logic [AWIDTH-1:0]      arr_wr_addr,
    output logic [DWIDTH-1:0]      arr_wr_data,
    input  logic                   rd_en,
    input  logic [AWIDTH-1:0]      rd_addr,
    output logic                   rd_ready,
    input  logic [DWIDTH-1:0]      arr_rd_data,
    output logic [DWIDTH-1:0]      rd_data,
    output logic                   init_done
);
    state_t            state, state_nxt;
    logic [AWIDTH-1:0] cnt;
    logic [NREQ-1:0]   vld, grant;
    logic              run, xfer;
    wreq_t             req0, req1, sel;

    assign run = state == RUN;
    // Requests are invisible to the arbiter until the array is initialised.
    assign vld = run ? wreq_valid : '0;

    arf132b256e1r1w0cbbehcaa4acw_rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (vld),
        .advance (xfer),
        .grant   (grant)
    );

    always_comb begin
        state_nxt  = (state == INIT && cnt == AWIDTH'(DEPTH-1)) ? RUN : state;
        wreq_ready = grant;
        xfer       = |grant;
        req0       = {wreq_addr[AWIDTH-1:0], wreq_data[DWIDTH-1:0]};
        req1       = {wreq_addr[2*AWIDTH-1:AWIDTH], wreq_data[2*DWIDTH-1:DWIDTH]};
        sel        = grant[1] ? req1 : req0;
        rd_ready   = run;
        init_done  = run;
        // Forward the staged write so a read never sees the pre-write array contents.
        rd_data    = (run && rd_en && arr_wr_en && rd_addr == arr_wr_addr) ? arr_wr_data : arr_rd_data;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= run ? cnt : cnt + 1'b1;
        end

    // Staging flops keep addr/data stable through the clk-low latch window.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            arr_wr_en   <= 1'b0;
            arr_wr_addr <= '0;
            arr_wr_data <= '0;
        end else if (!run) begin
            arr_wr_en   <= 1'b1;
            arr_wr_addr <= cnt;
            arr_wr_data <= '0;
        end else begin
            arr_wr_en <= xfer;
            if (xfer) begin
                arr_wr_addr <= sel.addr;
                arr_wr_data <= sel.data;
            end
        end
endmodule

// File: tb/tb_arf132b256e1r1w0cbbehcaa4acw_wr_ctrl.sv
// tb_arf132b256e1r1w0cbbehcaa4acw_wr_ctrl: randomized and directed checks against a behavioural model
module tb_arf132b256e1r1w0cbbehcaa4acw_wr_ctrl;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   wreq_valid = '0;
    logic [1:0]   wreq_ready;
    logic [15:0]  wreq_addr = '0;
    logic [263:0] wreq_data = '0;
    logic         arr_wr_en;
    logic [7:0]   arr_wr_addr;
    logic [131:0] arr_wr_data;
    logic         rd_en = 1'b0;
    logic [7:0]   rd_addr = '0;
    logic         rd_ready;
    logic [131:0] arr_rd_data = '0;
    logic [131:0] rd_data;
    logic         init_done;

    int tests = 0;
    int fails = 0;

    // model: initialisation progress, RR priority and the expected write-port contents
    bit           m_run;
    int           m_cnt;
    int           m_ptr;
    bit           m_en;
    logic [7:0]   m_addr;
    logic [131:0] m_data;
    int           init_writes;
    logic [131:0] last7f;

    arf132b256e1r1w0cbbehcaa4acw_wr_ctrl dut (
        .clk(clk), .rst_n(rst_n), .wreq_valid(wreq_valid), .wreq_ready(wreq_ready),
        .wreq_addr(wreq_addr), .wreq_data(wreq_data), .arr_wr_en(arr_wr_en),
        .arr_wr_addr(arr_wr_addr), .arr_wr_data(arr_wr_data), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_ready(rd_ready), .arr_rd_data(arr_rd_data),
        .rd_data(rd_data), .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [131:0] rnd132();
        logic [159:0] t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[131:0];
    endfunction

    function automatic int m_grant(logic [1:0] v);
        if (!m_run || v == 2'b00) return -1;
        if (v == 2'b11) return m_ptr;
        return v[0] ? 0 : 1;
    endfunction

    task automatic m_reset();
        m_run = 0; m_cnt = 0; m_ptr = 0; m_en = 0; m_addr = '0; m_data = '0;
    endtask

    task automatic set_req(input logic [1:0] v, input logic [7:0] a0, input logic [131:0] d0,
                           input logic [7:0] a1, input logic [131:0] d1);
        wreq_valid = v;
        wreq_addr  = {a1, a0};
        wreq_data  = {d1, d0};
    endtask

    // One cycle: check combinational outputs, clock, then check the staged write port.
    task automatic step();
        int g;
        logic [1:0]   exp_rdy;
        logic [131:0] exp_rd;
        #1;
        g       = m_grant(wreq_valid);
        exp_rdy = (g < 0) ? 2'b00 : 2'(1 << g);
        exp_rd  = (m_run && rd_en && m_en && rd_addr == m_addr) ? m_data : arr_rd_data;
        check("wreq_ready", wreq_ready, exp_rdy);
        check("rd_data", rd_data, exp_rd);
        check("rd_ready", rd_ready, m_run);
        check("init_done", init_done, m_run);
        @(posedge clk);
        if (!m_run) begin
            m_en = 1; m_addr = 8'(m_cnt); m_data = '0;
            m_cnt++;
            if (m_cnt == 256) m_run = 1;
        end else if (g >= 0) begin
            m_en   = 1;
            m_addr = wreq_addr[g*8 +: 8];
            m_data = wreq_data[g*132 +: 132];
            m_ptr  = 1 - g;
        end else
            m_en = 0;
        #1;
        check("arr_wr_en", arr_wr_en, m_en);
        check("arr_wr_addr", arr_wr_addr, m_addr);
        check("arr_wr_data", arr_wr_data, m_data);
        if (arr_wr_en && !init_done) init_writes++;
        if (arr_wr_en && arr_wr_addr == 8'h7f) last7f = arr_wr_data;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_wr_en", arr_wr_en, 1'b0);
        check("rst_init_done", init_done, 1'b0);
        check("rst_ready", wreq_ready, 2'b00);
        check("rst_addr", arr_wr_addr, 8'h00);
        m_reset();
        init_writes = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_wr_en", arr_wr_en, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_init_random();
        int n = 0;
        while (!m_run && n < 400) begin
            set_req(2'($urandom), 8'($urandom), rnd132(), 8'($urandom), rnd132());
            rd_en = 1'($urandom); rd_addr = m_addr; arr_rd_data = rnd132();
            step();
            n++;
        end
        check("init_len", 32'(n), 32'd256);
        check("init_writes", 32'(init_writes), 32'd255);
    endtask

    logic [131:0] a, b, c, d;

    initial begin
        m_reset();
        init_writes = 0;
        last7f = '0;
        #1;
        check("por_wr_en", arr_wr_en, 1'b0);
        check("por_init_done", init_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_init_random();
        set_req(2'b00, 0, 0, 0, 0); rd_en = 0;

        a = rnd132();
        set_req(2'b01, 8'h12, a, 8'h00, '0);
        step();
        set_req(2'b00, 0, 0, 0, 0);
        check("req0_en", arr_wr_en, 1'b1);
        check("req0_addr", arr_wr_addr, 8'h12);
        check("req0_data", arr_wr_data, a);
        step();
        check("req0_idle_en", arr_wr_en, 1'b0);

        c = rnd132(); d = rnd132();
        set_req(2'b11, 8'h7f, c, 8'h7f, d);
        #1 check("same_addr_g1", wreq_ready, 2'b10);
        step();
        #1 check("same_addr_g0", wreq_ready, 2'b01);
        step();
        set_req(2'b00, 0, 0, 0, 0);
        step();
        check("last_7f", last7f, c);

        set_req(2'b10, 8'h01, '0, 8'h02, rnd132());
        step();
        for (int i = 0; i < 4; i++) begin
            set_req(2'b11, 8'(8'h20 + i), rnd132(), 8'(8'h30 + i), rnd132());
            #1 check("rr_seq", wreq_ready, (i % 2) ? 2'b10 : 2'b01);
            step();
            check("rr_addr", arr_wr_addr, (i % 2) ? 8'(8'h30 + i) : 8'(8'h20 + i));
        end

        b = rnd132();
        set_req(2'b01, 8'h40, b, 8'h00, '0);
        step();
        set_req(2'b00, 0, 0, 0, 0);
        rd_en = 1; rd_addr = 8'h40; arr_rd_data = rnd132();
        #1 check("bypass_hit", rd_data, b);
        rd_addr = 8'h41;
        #1 check("bypass_miss", rd_data, arr_rd_data);
        step();
        rd_en = 0;

        for (int i = 0; i < 1500; i++) begin
            set_req(2'($urandom), 8'($urandom_range(0, 3)), rnd132(), 8'($urandom_range(0, 3)), rnd132());
            rd_en = 1'($urandom);
            rd_addr = $urandom_range(0, 1) ? m_addr : 8'($urandom);
            arr_rd_data = rnd132();
            step();
        end
        set_req(2'b00, 0, 0, 0, 0); rd_en = 0;

        do_reset();
        while (m_cnt < 100) step();
        do_reset();
        run_init_random();

        set_req(2'b10, 8'h00, '0, 8'h55, rnd132());
        step();
        set_req(2'b00, 0, 0, 0, 0);
        check("staged_before_rst", arr_wr_en, 1'b1);
        do_reset();
        step();
        check("restart_addr", arr_wr_addr, 8'h00);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
